// File: rtl/pfu.sv
// pfu: prefetch unit; fetches sequential words into an in-order buffer for decode.
// Define PFU_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module pfu #(
   parameter int unsigned P_FIFO_DEPTH   = 4,
   parameter logic [31:0] P_RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_ack_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   input  logic        ibus_rerr_i,
   output logic        pfu_dav_o,
   input  logic        pfu_pull_i,
   output logic        pfu_sofr_o,
   output logic [31:0] pfu_ins_o,
   output logic        pfu_ferr_o,
   output logic [31:0] pfu_pc_o
);

   localparam int AW = $clog2(P_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH = (CW+1)'(P_FIFO_DEPTH);

   typedef struct packed {
      logic        sofr;
      logic        ferr;
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t        mem [P_FIFO_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [CW-1:0] out_nxt;
   logic [31:0]   fa;
   logic [31:0]   rpc;
   logic [31:0]   jaddr;
   logic          sofr_f;

   logic          jump;
   logic          acc;
   logic          rv;
   logic          keep;
   logic          wr;
   logic          rd;
   logic          pull;
   logic          empty;
   logic          dav;
   logic [CW:0]   inflight;
   entry_t        rsp;
   entry_t        head;
   logic          unused_ok;

   assign unused_ok = &{1'b0, jump_addr_i[1:0]};
   assign jaddr     = {jump_addr_i[31:2], 2'b00};

   assign jump     = clk_en_i & jump_i;
   assign inflight = {1'b0, count} + {1'b0, outstanding};

   // Throttle counts in-flight stale words too, so the buffer cannot overflow.
   assign ibus_req_o  = ~reset_i & clk_en_i & ~jump_i & (inflight < DEPTH);
   assign ibus_addr_o = reset_i ? P_RESET_VECTOR : fa;

   assign acc     = ibus_req_o & ibus_ack_i;
   assign rv      = clk_en_i & ibus_rvalid_i;
   assign keep    = rv & (drop == '0) & ~jump;
   assign empty   = (count == '0);
   assign out_nxt = outstanding + CW'(acc) - CW'(rv);

   assign rsp = '{
      sofr: sofr_f,
      ferr: ibus_rerr_i,
      pc:   rpc,
      ins:  ibus_rdata_i
   };

`ifdef PFU_BYPASS_EN
   assign dav  = ~reset_i & (~empty | keep);
   assign head = empty ? rsp : mem[rp];
`else
   assign dav  = ~reset_i & ~empty;
   assign head = mem[rp];
`endif

   assign pull = clk_en_i & pfu_pull_i & dav & ~jump;
   assign rd   = pull & ~empty;
   // A word consumed straight off the bus never enters the buffer.
   assign wr   = keep & ~(pull & empty);

   assign pfu_dav_o  = dav;
   assign pfu_sofr_o = dav ? head.sofr : 1'b0;
   assign pfu_ferr_o = dav ? head.ferr : 1'b0;
   assign pfu_pc_o   = dav ? head.pc   : 32'h0;
   assign pfu_ins_o  = dav ? head.ins  : 32'h0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fa          <= P_RESET_VECTOR;
         rpc         <= P_RESET_VECTOR;
         sofr_f      <= 1'b1;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wp          <= '0;
         rp          <= '0;
      end else if (clk_en_i) begin
         outstanding <= out_nxt;
         if (jump) begin
            fa     <= jaddr;
            rpc    <= jaddr;
            sofr_f <= 1'b1;
            count  <= '0;
            wp     <= '0;
            rp     <= '0;
            drop   <= out_nxt;
         end else begin
            if (acc)
               fa <= fa + 32'd4;
            if (rv && drop != '0)
               drop <= drop - CW'(1);
            if (keep) begin
               rpc    <= rpc + 32'd4;
               sofr_f <= 1'b0;
            end
            if (wr)
               wp <= wp + AW'(1);
            if (rd)
               rp <= rp + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && wr)
         mem[wp] <= rsp;
   end

endmodule

// File: tb/tb_pfu.sv
// tb_pfu: randomized and directed checks of pfu against a bus/stream model.
// The model tracks requests by epoch; words requested before a jump/reset are stale.
module tb_pfu;

   localparam int DEPTH = 4;
   localparam logic [31:0] RV = 32'h0000_0000;
`ifdef PFU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        clk_en_i = 1'b1;
   logic        jump_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i = 1'b0;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic        ibus_rerr_i = 1'b0;
   logic        pfu_dav_o;
   logic        pfu_pull_i = 1'b0;
   logic        pfu_sofr_o;
   logic [31:0] pfu_ins_o;
   logic        pfu_ferr_o;
   logic [31:0] pfu_pc_o;

   pfu #(.P_FIFO_DEPTH(DEPTH), .P_RESET_VECTOR(RV)) dut (
      .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
      .jump_i(jump_i), .jump_addr_i(jump_addr_i),
      .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
      .ibus_ack_i(ibus_ack_i), .ibus_rvalid_i(ibus_rvalid_i),
      .ibus_rdata_i(ibus_rdata_i), .ibus_rerr_i(ibus_rerr_i),
      .pfu_dav_o(pfu_dav_o), .pfu_pull_i(pfu_pull_i),
      .pfu_sofr_o(pfu_sofr_o), .pfu_ins_o(pfu_ins_o),
      .pfu_ferr_o(pfu_ferr_o), .pfu_pc_o(pfu_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;
   typedef struct {
      logic [31:0] pc;
      logic        sofr;
   } ent_t;
   typedef struct {
      logic [31:0] pc;
      logic        sofr;
      logic        ferr;
   } obs_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          kept = 0;
   int          n_acc = 0;
   int          n_pull = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          first_rv = -1;
   int          first_dav = -1;
   logic [31:0] fa = RV;
   req_t        pend[$];
   ent_t        mbuf[$];
   obs_t        pull_log[$];
   logic [31:0] acc_log[$];

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   function automatic logic errfn(input logic [31:0] a);
      return a[5:2] == 4'd2;
   endfunction

   // The buffer must never hold more than DEPTH words.
   always @(negedge clk) begin
      if (!reset_i) begin
         checks++;
         if (dut.count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL overflow count %0d max %0d", dut.count, DEPTH);
         end
      end
   end

   task automatic model_reset();
      pend.delete();
      mbuf.delete();
      pull_log.delete();
      acc_log.delete();
      epoch++;
      kept = 0;
      fa = RV;
      n_acc = 0;
      n_pull = 0;
      first_rv = -1;
      first_dav = -1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_i = 1'b1;
      clk_en_i = 1'b1;
      ibus_ack_i = 1'b0;
      ibus_rvalid_i = 1'b0;
      pfu_pull_i = 1'b0;
      jump_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
   endtask

   task automatic cycle(input bit ce, input bit pull, input bit jmp,
                        input logic [31:0] ja, input bit ack, input bit rv_en);
      bit          have, keep, byp, exp_req, exp_dav, hsofr;
      logic [31:0] hpc;
      logic [65:0] exp_o, got_o;
      req_t        r;
      @(negedge clk);
      reset_i = 1'b0;
      clk_en_i = ce;
      pfu_pull_i = pull;
      jump_i = jmp;
      jump_addr_i = ja;
      ibus_ack_i = ack;
      have = ce && rv_en && pend.size() > 0;
      if (have)
         have = pend[0].due <= cyc;
      ibus_rvalid_i = have;
      if (have) begin
         ibus_rdata_i = memdata(pend[0].addr);
         ibus_rerr_i = errfn(pend[0].addr);
      end else begin
         ibus_rdata_i = $urandom;
         ibus_rerr_i = 1'($urandom);
      end
      #1;
      keep = 1'b0;
      if (have)
         keep = !jmp && pend[0].epoch == epoch;
      byp = BYP && keep && mbuf.size() == 0;
      exp_req = ce && !jmp && (pend.size() + mbuf.size() < DEPTH);
      checks++;
      if (ibus_req_o !== exp_req) begin
         errors++;
         $display("FAIL req cyc %0d got %b exp %b", cyc, ibus_req_o, exp_req);
      end
      if (exp_req) begin
         checks++;
         if (ibus_addr_o !== fa) begin
            errors++;
            $display("FAIL addr cyc %0d got %h exp %h", cyc, ibus_addr_o, fa);
         end
      end
      exp_dav = mbuf.size() > 0 || byp;
      checks++;
      if (pfu_dav_o !== exp_dav) begin
         errors++;
         $display("FAIL dav cyc %0d got %b exp %b", cyc, pfu_dav_o, exp_dav);
      end
      hpc = '0;
      hsofr = 1'b0;
      if (mbuf.size() > 0) begin
         hpc = mbuf[0].pc;
         hsofr = mbuf[0].sofr;
      end else if (byp) begin
         hpc = pend[0].addr;
         hsofr = kept == 0;
      end
      exp_o = exp_dav ? {hsofr, errfn(hpc), hpc, memdata(hpc)} : '0;
      got_o = {pfu_sofr_o, pfu_ferr_o, pfu_pc_o, pfu_ins_o};
      checks++;
      if (got_o !== exp_o) begin
         errors++;
         $display("FAIL head cyc %0d got %h exp %h", cyc, got_o, exp_o);
      end
      if (have && first_rv < 0)
         first_rv = cyc;
      if (pfu_dav_o === 1'b1 && first_dav < 0)
         first_dav = cyc;
      if (ce && !jmp && exp_dav && pull)
         pull_log.push_back('{pfu_pc_o, pfu_sofr_o, pfu_ferr_o});
      if (exp_req && ack)
         acc_log.push_back(ibus_addr_o);
      @(posedge clk);
      if (ce) begin
         if (jmp) begin
            epoch++;
            kept = 0;
            mbuf.delete();
            fa = {ja[31:2], 2'b00};
            if (have)
               r = pend.pop_front();
         end else begin
            if (exp_dav && pull) begin
               n_pull++;
               if (mbuf.size() > 0)
                  void'(mbuf.pop_front());
            end
            if (have) begin
               r = pend.pop_front();
               if (r.epoch == epoch) begin
                  if (!(byp && pull))
                     mbuf.push_back('{r.addr, kept == 0});
                  kept++;
               end
            end
            if (exp_req && ack) begin
               pend.push_back('{fa, epoch,
                  cyc + $urandom_range(lat_max, lat_min)});
               fa = fa + 32'd4;
               n_acc++;
            end
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      apply_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 5; i++)
         cycle(1, 1, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset_i = 1'b1;
         clk_en_i = 1'($urandom);
         pfu_pull_i = 1'($urandom);
         jump_i = 1'($urandom);
         jump_addr_i = $urandom;
         ibus_ack_i = 1'($urandom);
         ibus_rvalid_i = 1'b0;
         #1;
         checks++;
         if (ibus_req_o !== 1'b0 || ibus_addr_o !== RV) begin
            errors++;
            $display("FAIL rst_bus got %b %h exp 0 %h", ibus_req_o, ibus_addr_o, RV);
         end
         checks++;
         if ({pfu_dav_o, pfu_sofr_o, pfu_ferr_o, pfu_pc_o, pfu_ins_o} !== '0) begin
            errors++;
            $display("FAIL rst_out got dav %b pc %h ins %h exp 0", pfu_dav_o, pfu_pc_o, pfu_ins_o);
         end
         @(posedge clk);
      end
      model_reset();
      cycle(1, 0, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() != 1 || acc_log[0] !== RV) begin
         errors++;
         $display("FAIL rst_first_req got %0d reqs exp 1 at %h", acc_log.size(), RV);
      end
   endtask

   task automatic test_stream();
      apply_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 10; i++)
         cycle(1, 1, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() < 4 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 ||
          acc_log[2] !== 32'h8 || acc_log[3] !== 32'hC) begin
         errors++;
         $display("FAIL stream_addr got %0d reqs exp 0,4,8,C", acc_log.size());
      end
      checks++;
      if (pull_log.size() < 2 || pull_log[0].pc !== 32'h0 || pull_log[0].sofr !== 1'b1 ||
          pull_log[1].pc !== 32'h4 || pull_log[1].sofr !== 1'b0) begin
         errors++;
         $display("FAIL stream_first got %0d pulls exp pc0 sofr1 then pc4 sofr0", pull_log.size());
      end
      checks++;
      if (first_rv < 0 || first_dav - first_rv != (BYP ? 0 : 1)) begin
         errors++;
         $display("FAIL latency got %0d exp %0d", first_dav - first_rv, BYP ? 0 : 1);
      end
      n_pull = 0;
      for (int i = 0; i < 10; i++)
         cycle(1, 1, 0, 0, 1, 1);
      checks++;
      if (n_pull != 10) begin
         errors++;
         $display("FAIL throughput got %0d exp 10", n_pull);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 10; i++)
         cycle(1, 0, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() != DEPTH) begin
         errors++;
         $display("FAIL bp_fill got %0d exp %0d", acc_log.size(), DEPTH);
      end
      cycle(1, 1, 0, 0, 1, 1);
      for (int i = 0; i < 6; i++)
         cycle(1, 0, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() != DEPTH + 1) begin
         errors++;
         $display("FAIL bp_one got %0d exp %0d", acc_log.size(), DEPTH + 1);
      end
   endtask

   task automatic test_jump_drop();
      apply_reset();
      lat_min = 6;
      lat_max = 6;
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() != 3) begin
         errors++;
         $display("FAIL jd_out got %0d exp 3", acc_log.size());
      end
      cycle(1, 1, 1, 32'h1003, 1, 1);
      acc_log.delete();
      pull_log.delete();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 20; i++)
         cycle(1, 1, 0, 0, 1, 1);
      checks++;
      if (acc_log.size() == 0 || acc_log[0] !== 32'h1000) begin
         errors++;
         $display("FAIL jd_req got %0d reqs exp first 00001000", acc_log.size());
      end
      checks++;
      if (pull_log.size() == 0 || pull_log[0].pc !== 32'h1000 || pull_log[0].sofr !== 1'b1) begin
         errors++;
         $display("FAIL jd_head got %0d pulls exp pc 00001000 sofr 1", pull_log.size());
      end
   endtask

   task automatic test_jump_ack_rv();
      apply_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 6; i++)
         cycle(1, 1, 0, 0, 1, 1);
      cycle(1, 1, 1, 32'h2000, 1, 1);
      pull_log.delete();
      for (int i = 0; i < 10; i++)
         cycle(1, 1, 0, 0, 1, 1);
      checks++;
      if (pull_log.size() == 0 || pull_log[0].pc !== 32'h2000 || pull_log[0].sofr !== 1'b1) begin
         errors++;
         $display("FAIL jar_head got %0d pulls exp pc 00002000 sofr 1", pull_log.size());
      end
   endtask

   task automatic test_error();
      int idx;
      apply_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 12; i++)
         cycle(1, 1, 0, 0, 1, 1);
      idx = -1;
      foreach (pull_log[i])
         if (pull_log[i].pc === 32'h8 && idx < 0)
            idx = i;
      checks++;
      if (idx < 0 || pull_log[idx].ferr !== 1'b1) begin
         errors++;
         $display("FAIL err_head got idx %0d exp ferr 1 at pc 8", idx);
      end
      checks++;
      if (idx < 0 || idx + 1 >= pull_log.size() || pull_log[idx+1].pc !== 32'hC ||
          pull_log[idx+1].ferr !== 1'b0) begin
         errors++;
         $display("FAIL err_next got idx %0d exp pc C ferr 0", idx);
      end
   endtask

   task automatic test_random();
      logic [31:0] ja;
      apply_reset();
      lat_min = 1;
      lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         ja = $urandom;
         if ($urandom_range(3, 0) == 0)
            ja = {28'hFFFF_FFF, 2'b00, ja[1:0]} | {28'h0, ja[3:2], 2'b00};
         cycle($urandom_range(9, 0) != 0, $urandom_range(2, 0) != 0,
               $urandom_range(39, 0) == 0, ja,
               $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_jump_drop();
      test_jump_ack_rv();
      test_error();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
